// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if
//   Bundles the client-side handshake and the shared byte-level I2C master
//   signals around the three-way arbiter.
//   Client side (3 clients, client i in slice i):
//     req, enableIn, instructionIn[2i+1:2i], byteToSendIn[8i+7:8i],
//     completeOut, grant, timeoutFlag
//   Master side:
//     instructionI2C, enableI2C, byteToSendI2C (to master)
//     byteReceivedI2C, completeI2C             (from master)
//   Modports:
//     slave  - the arbiter's view (serves the clients, drives the master)
//     master - the environment's view (clients plus the byte-level master)
interface i2c_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  enableIn;
  logic [5:0]  instructionIn;
  logic [23:0] byteToSendIn;
  logic [2:0]  completeOut;
  logic [2:0]  grant;
  logic        timeoutFlag;
  logic [1:0]  instructionI2C;
  logic        enableI2C;
  logic [7:0]  byteToSendI2C;
  logic [7:0]  byteReceivedI2C;
  logic        completeI2C;

  modport slave (
    input  req, enableIn, instructionIn, byteToSendIn,
    input  byteReceivedI2C, completeI2C,
    output completeOut, grant, timeoutFlag,
    output instructionI2C, enableI2C, byteToSendI2C
  );

  modport master (
    output req, enableIn, instructionIn, byteToSendIn,
    output byteReceivedI2C, completeI2C,
    input  completeOut, grant, timeoutFlag,
    input  instructionI2C, enableI2C, byteToSendI2C
  );
endinterface

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Shares one byte-level I2C master between three clients. Round-robin,
//   per-transaction arbitration: the owner keeps the bus from grant until it
//   drops req. A watchdog reclaims the bus from an owner that holds req but
//   stops issuing instructions, by sending a STOP on its behalf and locking
//   that client out until it drops req.
//   Ports:
//     clk     - system clock
//     reset   - synchronous, active-high reset
//     bus     - i2c_arbiter_if.slave (client handshake + master signals)
//   Parameter:
//     TIMEOUT - idle cycles (req high, enable low) tolerated from the owner;
//               0 disables the watchdog.
module i2c_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic         clk,
  input  logic         reset,
  i2c_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    GRANTED,
    DRAIN,
    FORCE_STOP,
    GAP
  } state_t;

  localparam logic [1:0] INSTR_STOP = 2'd1;

  state_t      state, state_nx;
  logic [2:0]  grant_r, grant_nx;
  logic [1:0]  last, last_nx;
  logic [2:0]  lockout, lockout_nx;
  logic [15:0] wd_cnt, wd_cnt_nx;
  logic [1:0]  hold_instr;
  logic [7:0]  hold_byte;

  logic        own_req, own_en;
  logic [1:0]  own_instr;
  logic [7:0]  own_byte;

  logic [2:0]  eligible;
  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic        wd_fire;

  logic        en_o;
  logic [1:0]  instr_o;
  logic [7:0]  byte_o;
  logic [2:0]  cmp_o;
  logic        tflag_o;

  // Owner view: grant_r is one-hot (or zero), so it doubles as the select.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    own_req   = |(bus.req & grant_r);
    own_en    = |(bus.enableIn & grant_r);
    own_instr = '0;
    own_byte  = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant_r[i]) begin
        own_instr = bus.instructionIn[2*i +: 2];
        own_byte  = bus.byteToSendIn[8*i +: 8];
      end
    end
  end

  // Round-robin pick: first eligible client after the last one granted.
  always_comb begin : arb
    logic [2:0] cand;
    eligible  = bus.req & ~lockout;
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= 3; k++) begin
      cand = 3'(last) + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!sel_valid && eligible[cand[1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[1:0];
      end
    end
  end

  // Fires on the idle cycle that brings the count up to TIMEOUT.
  assign wd_fire = (TIMEOUT != 16'd0) && (state == GRANTED) && own_req &&
                   !own_en && ((wd_cnt + 16'd1) == TIMEOUT);

  always_comb begin
    state_nx   = state;
    grant_nx   = grant_r;
    last_nx    = last;
    wd_cnt_nx  = wd_cnt;
    lockout_nx = lockout & bus.req;   // a lockout ends once req drops
    en_o       = 1'b0;
    instr_o    = '0;
    byte_o     = '0;
    cmp_o      = '0;
    tflag_o    = 1'b0;

    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          grant_nx  = 3'b001 << sel_idx;
          last_nx   = sel_idx;
          wd_cnt_nx = '0;
          state_nx  = GRANTED;
        end
      end

      GRANTED: begin
        en_o    = own_en;
        instr_o = own_instr;
        byte_o  = own_byte;
        cmp_o   = grant_r & {3{bus.completeI2C}};

        if (own_en)
          wd_cnt_nx = '0;
        else if (own_req && (wd_cnt != 16'hFFFF))
          wd_cnt_nx = wd_cnt + 16'd1;

        if (!own_req) begin
          // An instruction in flight when req drops still has to finish.
          grant_nx = '0;
          state_nx = own_en ? DRAIN : GAP;
        end else if (wd_fire) begin
          lockout_nx = lockout_nx | grant_r;
          tflag_o    = 1'b1;
          grant_nx   = '0;
          state_nx   = FORCE_STOP;
        end
      end

      DRAIN: begin
        en_o    = 1'b1;
        instr_o = hold_instr;
        byte_o  = hold_byte;
        if (bus.completeI2C) state_nx = GAP;
      end

      FORCE_STOP: begin
        en_o    = 1'b1;
        instr_o = INSTR_STOP;
        if (bus.completeI2C) state_nx = GAP;
      end

      GAP: begin
        // One enable-low cycle lets the master re-arm before the next owner.
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // present before the edge, independent of statement order.
    if (reset) begin
      state   <= IDLE;
      grant_r <= '0;
      last    <= 2'd2;
      lockout <= '0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nx;
      grant_r <= grant_nx;
      last    <= last_nx;
      lockout <= lockout_nx;
      wd_cnt  <= wd_cnt_nx;
    end
  end

  // NOTE: the hold registers carry no reset; they are only read in DRAIN,
  // which is reachable only through a cycle that has just loaded them.
  always_ff @(posedge clk) begin
    if (state == GRANTED && own_en) begin
      hold_instr <= own_instr;
      hold_byte  <= own_byte;
    end
  end

  assign bus.grant          = grant_r;
  assign bus.enableI2C      = en_o;
  assign bus.instructionI2C = instr_o;
  assign bus.byteToSendI2C  = byte_o;
  assign bus.completeOut    = cmp_o;
  assign bus.timeoutFlag    = tflag_o;

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;

  localparam logic [1:0] I_START = 2'd0;
  localparam logic [1:0] I_STOP  = 2'd1;
  localparam logic [1:0] I_READ  = 2'd2;
  localparam logic [1:0] I_WRITE = 2'd3;

  typedef struct packed {
    logic [1:0] instr;
    logic [7:0] data;
  } mst_t;

  typedef struct {
    logic [2:0]  en;
    logic [5:0]  instr;
    logic [23:0] bytes;
    logic        cmp;
    logic        e_en;
    logic [1:0]  e_instr;
    logic [7:0]  e_byte;
    logic [2:0]  e_cmp;
  } vec_t;

  logic clk;
  logic reset;
  logic model_en;
  logic vec_complete;
  logic complete_raw;

  int n_checks = 0;
  int n_errors = 0;
  int pulses[3] = '{0, 0, 0};
  mst_t exp_q[$];

  i2c_arbiter_if bus();

  i2c_arbiter #(.TIMEOUT(16'd16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Master holds complete low whenever enable is low.
  assign bus.completeI2C = model_en ? (complete_raw & bus.enableI2C) : vec_complete;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // All stimulus changes 1ns after the rising edge; samples 3ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte-level master model: accepts on enable, completes 2 cycles later.
  initial begin : master_model
    bit busy;
    int wait_cnt;
    mst_t e;
    complete_raw = 1'b0;
    bus.byteReceivedI2C = 8'h00;
    busy = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!model_en || !bus.enableI2C) begin
        complete_raw = 1'b0;
        busy = 1'b0;
      end else if (!busy) begin
        busy = 1'b1;
        wait_cnt = 2;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got instr=%0d byte=%0h with nothing expected",
                   bus.instructionI2C, bus.byteToSendI2C);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", 32'(bus.instructionI2C), 32'(e.instr));
          check("sb_byte", 32'(bus.byteToSendI2C), 32'(e.data));
        end
      end else if (wait_cnt != 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          complete_raw = 1'b1;
          bus.byteReceivedI2C = bus.byteToSendI2C ^ 8'hFF;
        end
      end
    end
  end

  // Counts completeOut rising edges per client.
  initial begin : pulse_monitor
    logic [2:0] prev;
    prev = '0;
    forever begin
      @(posedge clk);
      #3;
      for (int i = 0; i < 3; i++)
        if (bus.completeOut[i] && !prev[i]) pulses[i]++;
      prev = bus.completeOut;
    end
  end

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    step();
    reset = 1'b1;
    bus.req = '0;
    bus.enableIn = '0;
    bus.instructionIn = '0;
    bus.byteToSendIn = '0;
    vec_complete = 1'b0;
    step();
    step();
    reset = 1'b0;
    #2;
  endtask

  task automatic client_op(input int c, input logic [1:0] ins, input logic [7:0] b);
    bit done;
    done = 1'b0;
    step();
    exp_q.push_back('{instr: ins, data: b});
    bus.enableIn[c] = 1'b1;
    bus.instructionIn[2*c +: 2] = ins;
    bus.byteToSendIn[8*c +: 8] = b;
    for (int t = 0; t < 20 && !done; t++) begin
      #2;
      if (bus.completeOut[c]) done = 1'b1;
      else step();
    end
    check("op_done", 32'(done), 32'd1);
    step();
    bus.enableIn[c] = 1'b0;
    #2;
  endtask

  // Owner drops req with enable low: GAP, IDLE, then the next grant.
  task automatic release_and_expect(input int c, input logic [2:0] nxt);
    step();
    bus.req[c] = 1'b0;
    #2;
    check("rel_hold", 32'(bus.grant), 32'(3'b001 << c));
    for (int k = 1; k <= 2; k++) begin
      step();
      #2;
      check("rel_gap_grant", 32'(bus.grant), 32'd0);
      check("rel_gap_en", 32'(bus.enableI2C), 32'd0);
    end
    step();
    #2;
    check("rel_next", 32'(bus.grant), 32'(nxt));
  endtask

  initial begin : main
    vec_t vecs[6];
    int base[3];
    int early;
    int dc;
    bit seen;

    // Passthrough vectors with client 1 as owner (fields listed client2,1,0).
    vecs[0] = '{3'b010, {2'd0, 2'd3, 2'd2}, {8'h11, 8'h5A, 8'h22}, 1'b0, 1'b1, 2'd3, 8'h5A, 3'b000};
    vecs[1] = '{3'b010, {2'd0, 2'd3, 2'd2}, {8'h11, 8'h5A, 8'h22}, 1'b1, 1'b1, 2'd3, 8'h5A, 3'b010};
    vecs[2] = '{3'b101, {2'd3, 2'd2, 2'd1}, {8'hFF, 8'hC3, 8'h00}, 1'b1, 1'b0, 2'd2, 8'hC3, 3'b010};
    vecs[3] = '{3'b111, {2'd1, 2'd0, 2'd3}, {8'h80, 8'h01, 8'h7F}, 1'b0, 1'b1, 2'd0, 8'h01, 3'b000};
    vecs[4] = '{3'b000, {2'd2, 2'd1, 2'd0}, {8'h00, 8'hFE, 8'hAA}, 1'b0, 1'b0, 2'd1, 8'hFE, 3'b000};
    vecs[5] = '{3'b110, {2'd3, 2'd3, 2'd3}, {8'h12, 8'h34, 8'h56}, 1'b1, 1'b1, 2'd3, 8'h34, 3'b010};

    reset = 1'b1;
    model_en = 1'b1;
    vec_complete = 1'b0;
    bus.req = '0;
    bus.enableIn = '0;
    bus.instructionIn = '0;
    bus.byteToSendIn = '0;

    // Reset values
    do_reset();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_complete", 32'(bus.completeOut), 32'd0);
    check("rst_tflag", 32'(bus.timeoutFlag), 32'd0);
    check("rst_en", 32'(bus.enableI2C), 32'd0);
    check("rst_instr", 32'(bus.instructionI2C), 32'd0);
    check("rst_byte", 32'(bus.byteToSendI2C), 32'd0);

    // Single client 1 transaction
    step();
    bus.req = 3'b010;
    #2;
    check("single_grant_n", 32'(bus.grant), 32'd0);
    step();
    #2;
    check("single_grant_n1", 32'(bus.grant), 32'b010);
    base = pulses;
    client_op(1, I_START, 8'h00);
    client_op(1, I_WRITE, 8'h90);
    client_op(1, I_WRITE, 8'h01);
    client_op(1, I_STOP, 8'h00);
    check("single_pulses1", 32'(pulses[1] - base[1]), 32'd4);
    check("single_pulses0", 32'(pulses[0] - base[0]), 32'd0);
    check("single_pulses2", 32'(pulses[2] - base[2]), 32'd0);

    // Table-driven passthrough while client 1 owns the bus
    model_en = 1'b0;
    for (int v = 0; v < 6; v++) begin
      step();
      bus.enableIn = vecs[v].en;
      bus.instructionIn = vecs[v].instr;
      bus.byteToSendIn = vecs[v].bytes;
      vec_complete = vecs[v].cmp;
      #2;
      check("vec_grant", 32'(bus.grant), 32'b010);
      check("vec_en", 32'(bus.enableI2C), 32'(vecs[v].e_en));
      check("vec_instr", 32'(bus.instructionI2C), 32'(vecs[v].e_instr));
      check("vec_byte", 32'(bus.byteToSendI2C), 32'(vecs[v].e_byte));
      check("vec_complete", 32'(bus.completeOut), 32'(vecs[v].e_cmp));
    end
    step();
    bus.enableIn = '0;
    bus.instructionIn = '0;
    bus.byteToSendIn = '0;
    vec_complete = 1'b0;
    #2;
    model_en = 1'b1;
    release_and_expect(1, 3'b000);

    // Contention: round-robin 0, 1, 2, then 0 on re-request
    do_reset();
    step();
    bus.req = 3'b111;
    #2;
    check("cont_grant_n", 32'(bus.grant), 32'd0);
    step();
    #2;
    check("cont_first", 32'(bus.grant), 32'b001);
    client_op(0, I_WRITE, 8'h42);
    release_and_expect(0, 3'b010);
    step();
    bus.req[0] = 1'b1;
    #2;
    release_and_expect(1, 3'b100);
    release_and_expect(2, 3'b001);
    release_and_expect(0, 3'b000);

    // Watchdog with TIMEOUT=16 on client 2
    do_reset();
    step();
    bus.req = 3'b100;
    #2;
    step();
    bus.req[0] = 1'b1;
    #2;
    check("wd_grant", 32'(bus.grant), 32'b100);
    exp_q.push_back('{instr: I_STOP, data: 8'h00});
    early = 0;
    for (int i = 1; i < 16; i++) begin
      if (bus.timeoutFlag) early++;
      step();
      #2;
    end
    check("wd_no_early_flag", 32'(early), 32'd0);
    check("wd_flag_16", 32'(bus.timeoutFlag), 32'd1);
    step();
    #2;
    check("wd_flag_pulse", 32'(bus.timeoutFlag), 32'd0);
    check("wd_revoked", 32'(bus.grant), 32'd0);
    check("wd_stop_en", 32'(bus.enableI2C), 32'd1);
    check("wd_stop_instr", 32'(bus.instructionI2C), 32'(I_STOP));
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step();
      #2;
      if (bus.grant != 3'b000) seen = 1'b1;
    end
    check("wd_next_owner", 32'(bus.grant), 32'b001);
    release_and_expect(0, 3'b000);
    seen = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      #2;
      if (bus.grant != 3'b000) seen = 1'b1;
    end
    check("wd_lockout_held", 32'(seen), 32'd0);
    step();
    bus.req[2] = 1'b0;
    #2;
    step();
    bus.req[2] = 1'b1;
    #2;
    seen = 1'b0;
    for (int t = 0; t < 5 && !seen; t++) begin
      step();
      #2;
      if (bus.grant != 3'b000) seen = 1'b1;
    end
    check("wd_regrant", 32'(bus.grant), 32'b100);
    step();
    bus.req = '0;
    #2;

    // Drain: client 0 drops req during a WRITE 0xA5
    do_reset();
    step();
    bus.req = 3'b001;
    #2;
    step();
    #2;
    check("drain_grant", 32'(bus.grant), 32'b001);
    step();
    exp_q.push_back('{instr: I_WRITE, data: 8'hA5});
    bus.enableIn[0] = 1'b1;
    bus.instructionIn[1:0] = I_WRITE;
    bus.byteToSendIn[7:0] = 8'hA5;
    bus.req[0] = 1'b0;
    #2;
    check("drain_pass_en", 32'(bus.enableI2C), 32'd1);
    step();
    bus.enableIn[0] = 1'b0;
    bus.instructionIn[1:0] = I_START;
    bus.byteToSendIn[7:0] = 8'h00;
    #2;
    dc = 0;
    for (int t = 0; t < 10 && bus.enableI2C; t++) begin
      check("drain_instr", 32'(bus.instructionI2C), 32'(I_WRITE));
      check("drain_byte", 32'(bus.byteToSendI2C), 32'hA5);
      check("drain_complete", 32'(bus.completeOut), 32'd0);
      dc++;
      step();
      #2;
    end
    check("drain_held", 32'(dc > 0), 32'd1);
    check("drain_gap_en", 32'(bus.enableI2C), 32'd0);
    step();
    #2;
    check("drain_idle_en", 32'(bus.enableI2C), 32'd0);
    check("drain_idle_grant", 32'(bus.grant), 32'd0);

    // Reset in the middle of a READ
    do_reset();
    step();
    bus.req = 3'b001;
    #2;
    step();
    #2;
    step();
    exp_q.push_back('{instr: I_READ, data: 8'h00});
    bus.enableIn[0] = 1'b1;
    bus.instructionIn[1:0] = I_READ;
    bus.byteToSendIn[7:0] = 8'h00;
    #2;
    check("mid_read_en", 32'(bus.enableI2C), 32'd1);
    step();
    reset = 1'b1;
    #2;
    step();
    reset = 1'b0;
    #2;
    check("mid_rst_grant", 32'(bus.grant), 32'd0);
    check("mid_rst_en", 32'(bus.enableI2C), 32'd0);
    check("mid_rst_instr", 32'(bus.instructionI2C), 32'd0);
    check("mid_rst_byte", 32'(bus.byteToSendI2C), 32'd0);
    check("mid_rst_complete", 32'(bus.completeOut), 32'd0);
    check("mid_rst_tflag", 32'(bus.timeoutFlag), 32'd0);
    step();
    bus.req = '0;
    bus.enableIn = '0;
    bus.instructionIn = '0;
    #2;
    step();
    #2;

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
